// File: rtl/logic_drv_pkg.sv
// logic_drv_pkg: shared state encoding, saturating arithmetic and parameter legality for the ramp driver
package logic_drv_pkg;

    typedef enum logic [1:0] {LOW, RISING, HIGH, FALLING} state_t;

    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] step, input logic [31:0] hi);
        logic [32:0] s;
        s = {1'b0, v} + {1'b0, step};
        return (s > {1'b0, hi}) ? hi : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] v, input logic [31:0] step, input logic [31:0] lo);
        return (v - lo < step) ? lo : v - step;
    endfunction

    function automatic bit params_ok(input int w, input int vmin, input int vmax, input int delay,
                                     input int rise, input int fall, input int thl, input int thh);
        return w >= 1 && w <= 31 && vmin >= 0 && vmin < vmax &&
               longint'(vmax) <= (longint'(1) << w) - 1 &&
               delay >= 0 && delay <= 15 && rise >= 1 && fall >= 1 &&
               vmin <= thl && thl < thh && thh <= vmax;
    endfunction

endpackage

// File: rtl/logic_delay_line.sv
// logic_delay_line: transport delay of a 1-bit stream by DELAY enabled edges (DELAY=0 is a wire)
module logic_delay_line #(
    parameter int DELAY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    if (DELAY == 0) begin : g_wire
        logic unused;
        assign unused = clk ^ rst_n ^ en;
        assign q = d;
    end else begin : g_sr
        logic [DELAY-1:0] sr;
        // shift one sample per enabled edge; every pulse survives regardless of width
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr <= '0;
            end else if (en) begin
                sr[0] <= d;
                for (int i = DELAY - 1; i > 0; i--) sr[i] <= sr[i-1];
            end
        end
        assign q = sr[DELAY-1];
    end

endmodule

// File: rtl/logic_ramp_driver.sv
// logic_ramp_driver: slews a W-bit voltage code between rails following a delayed logic input, with hysteresis loopback
module logic_ramp_driver import logic_drv_pkg::*; #(
    parameter int W         = 8,
    parameter int VMIN      = 0,
    parameter int VMAX      = 255,
    parameter int DELAY     = 2,
    parameter int RISE_STEP = 64,
    parameter int FALL_STEP = 51,
    parameter int THH       = 230,
    parameter int THL       = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         d_in,
    output logic [W-1:0] v_out,
    output logic         level,
    output logic         lvl_chg,
    output logic         busy
);

    if (!params_ok(W, VMIN, VMAX, DELAY, RISE_STEP, FALL_STEP, THL, THH)) begin : g_bad_params
        $error("logic_ramp_driver: illegal parameter set");
    end

    localparam logic [W-1:0] LO   = W'(VMIN);
    localparam logic [W-1:0] HI   = W'(VMAX);
    localparam logic [W-1:0] TH_H = W'(THH);
    localparam logic [W-1:0] TH_L = W'(THL);

    logic         target;
    state_t       state, nstate;
    logic [W-1:0] nv;
    logic         nlevel;

    logic_delay_line #(.DELAY(DELAY)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (d_in),
        .q     (target)
    );

    // step toward the rail selected by target; a reversal continues from the current code
    always_comb begin
        nstate = state;
        nv     = v_out;
        if (target && state != HIGH) begin
            nv     = W'(sat_add(32'(v_out), 32'(RISE_STEP), 32'(VMAX)));
            nstate = (nv == HI) ? HIGH : RISING;
        end else if (!target && state != LOW) begin
            nv     = W'(sat_sub(32'(v_out), 32'(FALL_STEP), 32'(VMIN)));
            nstate = (nv == LO) ? LOW : FALLING;
        end
        nlevel = (nv >= TH_H) ? 1'b1 : (nv <= TH_L) ? 1'b0 : level;
    end

    // register state, code and loopback level together; a frozen block only drops the change pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOW;
            v_out   <= LO;
            level   <= 1'b0;
            lvl_chg <= 1'b0;
            busy    <= 1'b0;
        end else if (en) begin
            state   <= nstate;
            v_out   <= nv;
            level   <= nlevel;
            lvl_chg <= nlevel ^ level;
            busy    <= (nstate == RISING) || (nstate == FALLING);
        end else begin
            lvl_chg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_ramp_driver.sv
// tb_logic_ramp_driver: vector table, corner sequences and randomized run against a saturating-integrator model
module tb_logic_ramp_driver;

    localparam int VMIN = 0, VMAX = 255, DLY = 2, RS = 64, FS = 51, THH = 230, THL = 25;

    typedef struct {
        bit d;
        bit e;
        int v;
        bit b;
        bit l;
        bit c;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, d_in = 1'b0;
    logic       en1 = 1'b1, d1 = 1'b0;
    logic [7:0] v_out, v1;
    logic       level, lvl_chg, busy, level1, chg1, busy1;
    int         checks = 0, errors = 0;
    bit         saw_busy1 = 1'b0;
    vec_t       tbl[$];

    int m_v, m_l, m_c, m_b;
    bit hist[$];

    logic_ramp_driver #(.W(8), .VMIN(VMIN), .VMAX(VMAX), .DELAY(DLY), .RISE_STEP(RS),
                        .FALL_STEP(FS), .THH(THH), .THL(THL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .d_in(d_in),
        .v_out(v_out), .level(level), .lvl_chg(lvl_chg), .busy(busy)
    );

    logic_ramp_driver #(.W(8), .VMIN(0), .VMAX(255), .DELAY(0), .RISE_STEP(300),
                        .FALL_STEP(300), .THH(230), .THL(25)) u_full (
        .clk(clk), .rst_n(rst_n), .en(en1), .d_in(d1),
        .v_out(v1), .level(level1), .lvl_chg(chg1), .busy(busy1)
    );

    // free-running clock
    always #5 clk = ~clk;

    // the full-swing instance must never report a ramp in progress
    always @(negedge clk) if (busy1) saw_busy1 = 1'b1;

    // hard stop if the run ever stalls
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_v = VMIN; m_l = 0; m_c = 0; m_b = 0;
        hist.delete();
    endtask

    task automatic model_edge(input bit d, input bit e);
        bit tgt;
        int nl;
        if (!e) begin
            m_c = 0;
        end else begin
            hist.push_back(d);
            if (hist.size() > 20) void'(hist.pop_front());
            tgt = (hist.size() > DLY) ? hist[hist.size() - 1 - DLY] : 1'b0;
            m_v = tgt ? ((m_v + RS > VMAX) ? VMAX : m_v + RS) : ((m_v - FS < VMIN) ? VMIN : m_v - FS);
            nl  = (m_v >= THH) ? 1 : (m_v <= THL) ? 0 : m_l;
            m_c = (nl != m_l) ? 1 : 0;
            m_l = nl;
            m_b = tgt ? (m_v != VMAX) : (m_v != VMIN);
        end
    endtask

    task automatic tick(input bit d, input bit e);
        d_in = d;
        en   = e;
        @(posedge clk);
        if (rst_n) model_edge(d, e);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_v"}, int'(v_out), m_v);
        chk({tag, "_level"}, int'(level), m_l);
        chk({tag, "_chg"}, int'(lvl_chg), m_c);
        chk({tag, "_busy"}, int'(busy), m_b);
    endtask

    task automatic add(input bit d, input bit e, input int v, input bit b, input bit l, input bit c);
        vec_t x;
        x.d = d; x.e = e; x.v = v; x.b = b; x.l = l; x.c = c;
        tbl.push_back(x);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_v", int'(v_out), 0);
        chk("reset_level", int'(level), 0);
        chk("reset_chg", int'(lvl_chg), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;

        // rise, freeze right after the level pulse, then fall
        add(1,1,0,0,0,0);   add(1,1,0,0,0,0);   add(1,1,64,1,0,0);  add(1,1,128,1,0,0);
        add(1,1,192,1,0,0); add(1,1,255,0,1,1); add(1,0,255,0,1,0); add(0,1,255,0,1,0);
        add(0,1,255,0,1,0); add(0,1,204,1,1,0); add(0,1,153,1,1,0); add(0,1,102,1,1,0);
        add(0,1,51,1,1,0);  add(0,1,0,0,0,1);   add(0,1,0,0,0,0);
        // one-cycle glitch reverses mid-ramp without moving the level
        add(1,1,0,0,0,0);   add(0,1,0,0,0,0);   add(0,1,64,1,0,0);  add(0,1,13,1,0,0);
        add(0,1,0,0,0,0);   add(0,1,0,0,0,0);
        // freeze at 128 with d_in toggling, then resume with shifted timing
        add(1,1,0,0,0,0);   add(1,1,0,0,0,0);   add(1,1,64,1,0,0);  add(1,1,128,1,0,0);
        add(0,0,128,1,0,0); add(1,0,128,1,0,0); add(0,0,128,1,0,0); add(0,1,192,1,0,0);
        add(0,1,255,0,1,1); add(0,1,204,1,1,0); add(0,1,153,1,1,0); add(0,1,102,1,1,0);
        add(0,1,51,1,1,0);  add(0,1,0,0,0,1);   add(0,1,0,0,0,0);

        foreach (tbl[i]) begin
            tick(tbl[i].d, tbl[i].e);
            chk($sformatf("vec%0d_v", i), int'(v_out), tbl[i].v);
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].b));
            chk($sformatf("vec%0d_level", i), int'(level), int'(tbl[i].l));
            chk($sformatf("vec%0d_chg", i), int'(lvl_chg), int'(tbl[i].c));
        end

        // asynchronous reset in the middle of a rise
        repeat (4) tick(1, 1);
        chk("pre_rst_v", int'(v_out), 128);
        #2;
        rst_n = 1'b0;
        d_in  = 1'b0;
        #1;
        chk("async_rst_v", int'(v_out), 0);
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_busy", int'(busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(0, 1);
            chk($sformatf("post_rst%0d_v", i), int'(v_out), 0);
        end

        // randomized run with sticky input and sporadic freezes
        for (int i = 0; i < 300; i++) begin
            tick(($urandom_range(0, 3) == 0) ? ~d_in : d_in, $urandom_range(0, 4) != 0);
            check_model($sformatf("rnd%0d", i));
        end

        // zero delay, full-swing steps: one-edge ramps, never busy
        d1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("full_rise_v", int'(v1), 255);
        chk("full_rise_level", int'(level1), 1);
        chk("full_rise_chg", int'(chg1), 1);
        chk("full_rise_busy", int'(busy1), 0);
        @(posedge clk);
        @(negedge clk);
        chk("full_hold_chg", int'(chg1), 0);
        d1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("full_fall_v", int'(v1), 0);
        chk("full_fall_level", int'(level1), 0);
        chk("full_fall_chg", int'(chg1), 1);
        chk("full_never_busy", int'(saw_busy1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
